// File: rtl/ysyx_210184_wb_ctrl_pkg.sv
// Shared types for the writeback controller: result payload and scoreboard lookup.
`include "defines.v"

package ysyx_210184_wb_ctrl_pkg;
  localparam int XLEN = $bits(logic [`REG_BUS]);

  typedef logic [XLEN-1:0] reg_t;

  typedef struct packed {
    logic [4:0] rd;
    reg_t       data;
  } wb_res_t;

  // x0 is hardwired, so it never reports busy.
  function automatic logic reg_busy(input logic [31:1] busy, input logic [4:0] idx);
    return (idx == 5'd0) ? 1'b0 : busy[idx];
  endfunction
endpackage

// File: rtl/defines.v
// Global widths and writeback-controller defaults shared across the core.
`ifndef YSYX_210184_DEFINES_V
`define YSYX_210184_DEFINES_V
`define REG_BUS       63:0
`define WB_FIFO_DEPTH 2
`define WB_STARVE_MAX 4
`endif

// File: rtl/ysyx_210184_wb_ctrl_fifo.sv
// Skid FIFO holding LSU results until the writeback arbiter drains them.
module ysyx_210184_wb_fifo
  import ysyx_210184_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = `WB_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_res_t push_res,
  input  logic    pop,
  output wb_res_t head,
  output logic    full,
  output logic    empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_res_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_res;
  end
endmodule

// File: rtl/ysyx_210184_wb_ctrl.sv
// Writeback controller: register scoreboard, ALU/LSU arbitration with starvation guard,
// and a registered register-file write port.
module ysyx_210184_wb_ctrl
  import ysyx_210184_wb_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = `WB_FIFO_DEPTH,
  parameter int STARVE_MAX = `WB_STARVE_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iss_valid,
  input  logic [4:0] iss_rd,
  input  logic [4:0] iss_rs1,
  input  logic [4:0] iss_rs2,
  output logic       iss_stall,
  input  logic       alu_valid,
  output logic       alu_ready,
  input  logic [4:0] alu_rd,
  input  reg_t       alu_data,
  input  logic       lsu_valid,
  output logic       lsu_ready,
  input  logic [4:0] lsu_rd,
  input  reg_t       lsu_data,
  output logic       w_ena,
  output logic [4:0] w_addr,
  output reg_t       w_data
);
  localparam int SW = $clog2(STARVE_MAX) + 1;

  logic [31:1]   busy_q, busy_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          w_ena_q;
  logic [4:0]    w_addr_q;
  reg_t          w_data_q;

  wb_res_t fifo_head, sel_res;
  logic    fifo_full, fifo_empty;
  logic    starve_hit, sel_alu, sel_fifo, sel_any, sel_wr, iss_acc;

  ysyx_210184_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (lsu_valid & lsu_ready),
    .push_res (wb_res_t'{rd: lsu_rd, data: lsu_data}),
    .pop      (sel_fifo),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign iss_stall = iss_valid & (~rst_n | reg_busy(busy_q, iss_rs1) |
                                  reg_busy(busy_q, iss_rs2) | reg_busy(busy_q, iss_rd));
  assign iss_acc   = iss_valid & ~iss_stall;

  // After STARVE_MAX-1 consecutive ALU wins over a waiting LSU result, hold the ALU off.
  assign starve_hit = (starve_q == SW'(STARVE_MAX - 1)) & ~fifo_empty;
  assign alu_ready  = rst_n & ~starve_hit;
  assign lsu_ready  = rst_n & ~fifo_full;

  assign sel_alu  = alu_valid & alu_ready;
  assign sel_fifo = rst_n & ~sel_alu & ~fifo_empty;
  assign sel_any  = sel_alu | sel_fifo;
  assign sel_res  = sel_alu ? wb_res_t'{rd: alu_rd, data: alu_data} : fifo_head;
  assign sel_wr   = sel_any & (sel_res.rd != 5'd0);

  always_comb begin
    busy_d = busy_q;
    if (sel_wr) busy_d[sel_res.rd] = 1'b0;
    // Applied after the clear so a same-cycle reservation of the written index survives.
    if (iss_acc && iss_rd != 5'd0) busy_d[iss_rd] = 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || sel_fifo) starve_d = '0;
    else if (sel_alu)           starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      starve_q <= '0;
      w_ena_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
      w_ena_q  <= sel_wr;
      if (sel_wr) begin
        w_addr_q <= sel_res.rd;
        w_data_q <= sel_res.data;
      end
    end
  end

  assign w_ena  = w_ena_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;
endmodule

// File: tb/tb_ysyx_210184_wb_ctrl.sv
// Directed bench for the writeback controller with hand-computed expectations.
module tb_ysyx_210184_wb_ctrl;
  import ysyx_210184_wb_ctrl_pkg::*;

  logic       clk, rst_n;
  logic       iss_valid, iss_stall;
  logic [4:0] iss_rd, iss_rs1, iss_rs2;
  logic       alu_valid, alu_ready, lsu_valid, lsu_ready, w_ena;
  logic [4:0] alu_rd, lsu_rd, w_addr;
  reg_t       alu_data, lsu_data, w_data;

  int vecs = 0;
  int errs = 0;

  ysyx_210184_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout vecs=%0d", vecs);
    $fatal(1, "timeout");
  end

  task automatic idle();
    iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = '0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); iss_valid = 1; #2;
    vecs++; if (w_ena !== 1'b0) begin errs++; $display("FAIL rst_w_ena got %b exp 0", w_ena); end
    vecs++; if (w_addr !== 5'd0) begin errs++; $display("FAIL rst_w_addr got %0d exp 0", w_addr); end
    vecs++; if (w_data !== '0) begin errs++; $display("FAIL rst_w_data got %h exp 0", w_data); end
    vecs++; if (alu_ready !== 1'b0) begin errs++; $display("FAIL rst_alu_ready got %b exp 0", alu_ready); end
    vecs++; if (lsu_ready !== 1'b0) begin errs++; $display("FAIL rst_lsu_ready got %b exp 0", lsu_ready); end
    vecs++; if (iss_stall !== 1'b1) begin errs++; $display("FAIL rst_stall got %b exp 1", iss_stall); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1; iss_valid = 0; #1;
    vecs++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL rel_alu_ready got %b exp 1", alu_ready); end
    vecs++; if (lsu_ready !== 1'b1) begin errs++; $display("FAIL rel_lsu_ready got %b exp 1", lsu_ready); end
    vecs++; if (iss_stall !== 1'b0) begin errs++; $display("FAIL rel_stall got %b exp 0", iss_stall); end
  endtask

  task automatic test_raw_hazard();
    iss_valid = 1; iss_rd = 5; #1;
    vecs++; if (iss_stall !== 1'b0) begin errs++; $display("FAIL raw_issue got %b exp 0", iss_stall); end
    tick();
    iss_rd = 6; iss_rs1 = 5; alu_valid = 1; alu_rd = 5; alu_data = 64'hA5; #1;
    vecs++; if (iss_stall !== 1'b1) begin errs++; $display("FAIL raw_stall_N got %b exp 1", iss_stall); end
    vecs++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL raw_alu_ready got %b exp 1", alu_ready); end
    tick();
    vecs++; if (w_ena !== 1'b1) begin errs++; $display("FAIL raw_w_ena got %b exp 1", w_ena); end
    vecs++; if (w_addr !== 5'd5) begin errs++; $display("FAIL raw_w_addr got %0d exp 5", w_addr); end
    vecs++; if (w_data !== 64'hA5) begin errs++; $display("FAIL raw_w_data got %h exp a5", w_data); end
    alu_valid = 0; #1;
    vecs++; if (iss_stall !== 1'b0) begin errs++; $display("FAIL raw_stall_N1 got %b exp 0", iss_stall); end
    tick();
    vecs++; if (w_ena !== 1'b0) begin errs++; $display("FAIL raw_idle_w_ena got %b exp 0", w_ena); end
    vecs++; if (w_addr !== 5'd5 || w_data !== 64'hA5) begin errs++; $display("FAIL raw_hold got %0d/%h exp 5/a5", w_addr, w_data); end
    iss_valid = 0; alu_valid = 1; alu_rd = 6; alu_data = 64'h66;
    tick();
    alu_valid = 0; iss_valid = 1; iss_rd = 0; iss_rs1 = 6; #1;
    vecs++; if (iss_stall !== 1'b0) begin errs++; $display("FAIL raw_clear6 got %b exp 0", iss_stall); end
    idle();
  endtask

  task automatic test_dual_source();
    alu_valid = 1; alu_rd = 1; alu_data = 64'h11;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 64'h22; #1;
    vecs++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin errs++; $display("FAIL dual_ready got %b%b exp 11", alu_ready, lsu_ready); end
    tick(); idle();
    vecs++; if (w_ena !== 1'b1 || w_addr !== 5'd1 || w_data !== 64'h11) begin errs++; $display("FAIL dual_alu got %b/%0d/%h exp 1/1/11", w_ena, w_addr, w_data); end
    tick();
    vecs++; if (w_ena !== 1'b1 || w_addr !== 5'd2 || w_data !== 64'h22) begin errs++; $display("FAIL dual_lsu got %b/%0d/%h exp 1/2/22", w_ena, w_addr, w_data); end
    tick();
    vecs++; if (w_ena !== 1'b0) begin errs++; $display("FAIL dual_idle got %b exp 0", w_ena); end
  endtask

  task automatic test_starvation();
    int exp_ar [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1};
    int exp_lr [10] = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int exp_wa [10] = '{10, 11, 12, 13, 20, 14, 15, 16, 21, 17};
    int ai = 0, li = 0;
    reg_t ed;
    for (int c = 0; c < 10; c++) begin
      alu_valid = 1; alu_rd = 5'(10 + ai); alu_data = reg_t'(64'h100 + ai);
      lsu_valid = (li < 3); lsu_rd = 5'(20 + li); lsu_data = reg_t'(64'h200 + li); #1;
      vecs++; if (alu_ready !== 1'(exp_ar[c])) begin errs++; $display("FAIL starve_alu_ready c%0d got %b exp %0d", c, alu_ready, exp_ar[c]); end
      vecs++; if (lsu_ready !== 1'(exp_lr[c])) begin errs++; $display("FAIL starve_lsu_ready c%0d got %b exp %0d", c, lsu_ready, exp_lr[c]); end
      if (lsu_valid && lsu_ready) li++;
      if (alu_ready) ai++;
      tick();
      ed = (exp_wa[c] >= 20) ? reg_t'(64'h200 + exp_wa[c] - 20) : reg_t'(64'h100 + exp_wa[c] - 10);
      vecs++; if (w_ena !== 1'b1 || w_addr !== 5'(exp_wa[c]) || w_data !== ed) begin errs++; $display("FAIL starve_wb c%0d got %b/%0d/%h exp 1/%0d/%h", c, w_ena, w_addr, w_data, exp_wa[c], ed); end
    end
    idle(); tick();
    vecs++; if (w_ena !== 1'b1 || w_addr !== 5'd22 || w_data !== 64'h202) begin errs++; $display("FAIL starve_drain got %b/%0d/%h exp 1/22/202", w_ena, w_addr, w_data); end
    tick();
    vecs++; if (w_ena !== 1'b0 || lsu_ready !== 1'b1) begin errs++; $display("FAIL starve_empty got %b/%b exp 0/1", w_ena, lsu_ready); end
  endtask

  task automatic test_rd_zero();
    iss_valid = 1; iss_rd = 3; tick();
    iss_valid = 0; alu_valid = 1; alu_rd = 0; alu_data = 64'hFFFF; #1;
    vecs++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL rd0_ready got %b exp 1", alu_ready); end
    tick(); idle();
    vecs++; if (w_ena !== 1'b0) begin errs++; $display("FAIL rd0_w_ena got %b exp 0", w_ena); end
    vecs++; if (w_addr !== 5'd22 || w_data !== 64'h202) begin errs++; $display("FAIL rd0_hold got %0d/%h exp 22/202", w_addr, w_data); end
    iss_valid = 1; iss_rs1 = 3; #1;
    vecs++; if (iss_stall !== 1'b1) begin errs++; $display("FAIL rd0_busy3 got %b exp 1", iss_stall); end
    iss_rs1 = 0; #1;
    vecs++; if (iss_stall !== 1'b0) begin errs++; $display("FAIL rd0_x0 got %b exp 0", iss_stall); end
    iss_valid = 0; alu_valid = 1; alu_rd = 3; alu_data = 64'h3; tick(); idle();
  endtask

  task automatic test_issue_vs_wb();
    alu_valid = 1; alu_rd = 9; alu_data = 64'h99; iss_valid = 1; iss_rd = 9; #1;
    vecs++; if (iss_stall !== 1'b0) begin errs++; $display("FAIL same9_stall got %b exp 0", iss_stall); end
    tick(); idle();
    vecs++; if (w_ena !== 1'b1 || w_addr !== 5'd9) begin errs++; $display("FAIL same9_wb got %b/%0d exp 1/9", w_ena, w_addr); end
    iss_valid = 1; iss_rs2 = 9; #1;
    vecs++; if (iss_stall !== 1'b1) begin errs++; $display("FAIL same9_busy got %b exp 1", iss_stall); end
    idle();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_rd = 0; alu_data = 64'h1;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 64'h44; iss_valid = 1; iss_rd = 7; #1;
    vecs++; if (lsu_ready !== 1'b1) begin errs++; $display("FAIL mid_push0 got %b exp 1", lsu_ready); end
    tick();
    iss_valid = 0; lsu_rd = 5; lsu_data = 64'h55; #1;
    vecs++; if (lsu_ready !== 1'b1) begin errs++; $display("FAIL mid_push1 got %b exp 1", lsu_ready); end
    tick(); idle();
    iss_valid = 1; iss_rs1 = 7; #1;
    vecs++; if (lsu_ready !== 1'b0 || iss_stall !== 1'b1) begin errs++; $display("FAIL mid_pre got %b/%b exp 0/1", lsu_ready, iss_stall); end
    rst_n = 0; #1;
    vecs++; if (w_ena !== 1'b0 || w_addr !== 5'd0 || w_data !== '0) begin errs++; $display("FAIL mid_rst_w got %b/%0d/%h exp 0/0/0", w_ena, w_addr, w_data); end
    vecs++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin errs++; $display("FAIL mid_rst_ready got %b/%b exp 0/0", alu_ready, lsu_ready); end
    vecs++; if (iss_stall !== 1'b1) begin errs++; $display("FAIL mid_rst_stall got %b exp 1", iss_stall); end
    tick();
    rst_n = 1; #1;
    vecs++; if (iss_stall !== 1'b0 || lsu_ready !== 1'b1) begin errs++; $display("FAIL mid_rel got %b/%b exp 0/1", iss_stall, lsu_ready); end
    idle();
    for (int c = 0; c < 4; c++) begin
      tick();
      vecs++; if (w_ena !== 1'b0) begin errs++; $display("FAIL mid_quiet c%0d got %b exp 0", c, w_ena); end
    end
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_dual_source();
    test_starvation();
    test_rd_zero();
    test_issue_vs_wb();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ysyx_210184_wb_ctrl.md
YSYX_210184_WB_CTRL -- requirements
Module: ysyx_210184_wb_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: iss_valid in 1 decode issuing; iss_rd in 5 destination; iss_rs1, iss_rs2 in 5 each, sources; iss_stall out 1 hazard, issue not accepted.
REQ-003 SHALL have ports: alu_valid in 1; alu_ready out 1; alu_rd in 5; alu_data in `REG_BUS` single-cycle result.
REQ-004 SHALL have ports: lsu_valid in 1; lsu_ready out 1; lsu_rd in 5; lsu_data in `REG_BUS` long-latency result.
REQ-005 SHALL have ports: w_ena out 1; w_addr out 5; w_data out `REG_BUS`; all three drive the register file write port.
REQ-006 SHALL use parameters: FIFO_DEPTH, default 2, LSU skid entries; STARVE_MAX, default 4, consecutive ALU wins before the FIFO is forced.

Function
REQ-007 SHALL keep busy[31:1], one bit per register; x0 is never busy.
REQ-008 iss_stall SHALL equal iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]), combinational, with busy[0] read as 0.
REQ-009 An issue is accepted when iss_valid & !iss_stall; if iss_rd!=0 it SHALL set busy[iss_rd] at that edge.
REQ-010 LSU results SHALL enter a FIFO_DEPTH-entry FIFO; lsu_ready = !full; push on lsu_valid & lsu_ready.
REQ-011 Each cycle the writeback source SHALL be ALU if alu_valid & alu_ready, else FIFO head if not empty, else none.
REQ-012 The selected result SHALL be registered onto w_ena/w_addr/w_data at the next edge (1-cycle latency); w_ena=1 only if the selected rd!=0.
REQ-013 A result with rd=0 SHALL be consumed (handshake/pop) with w_ena=0.
REQ-014 The selected rd's busy bit SHALL clear at the same edge that loads w_*; if an issue sets the same index in that cycle, set wins.
REQ-015 The FIFO head SHALL pop only when it is selected; a push and a pop in the same cycle SHALL both occur, including when the FIFO is full (lsu_ready stays low when full).
REQ-016 starve_cnt SHALL increment when ALU is selected while the FIFO is non-empty, and SHALL reset to 0 on any pop or when the FIFO is empty.
REQ-017 alu_ready SHALL be 0 when starve_cnt==STARVE_MAX-1 and the FIFO is non-empty, otherwise 1; the FIFO then wins that cycle.
REQ-018 When w_ena is deasserted, w_addr and w_data SHALL hold their previous values.

Reset
REQ-019 rst_n low SHALL asynchronously clear busy, the FIFO pointers and count, starve_cnt, w_ena, w_addr and w_data to 0.
REQ-020 During reset, lsu_ready=0, alu_ready=0 and iss_stall=iss_valid.
REQ-021 Reset asserted mid-operation SHALL discard all FIFO contents and pending reservations; no write issues after release until new input arrives.

Structure
REQ-022 `REG_BUS` SHALL come from defines.v; FIFO_DEPTH and STARVE_MAX defaults SHALL live in defines.v as WB_FIFO_DEPTH and WB_STARVE_MAX.
REQ-023 The FIFO SHALL be a sub-module ysyx_210184_wb_fifo (data+rd, push/pop, full/empty); arbitration, the scoreboard and the output register SHALL stay in the top.

Verification
REQ-024 Issue rd=5, then alu_valid rd=5 data=0xA5 in cycle N -> w_ena=1, w_addr=5, w_data=0xA5 in cycle N+1; busy[5]=0 from N+1; an issue with rs1=5 stalls in N and is accepted in N+1.
REQ-025 alu_valid and lsu_valid both high with the FIFO empty -> ALU written in N+1, LSU written in N+2.
REQ-026 alu_valid held high for 10 cycles with LSU pushing 3 results -> lsu_ready=0 after 2 pushes; alu_ready=0 in exactly one cycle after 4 ALU wins; the FIFO head writes in that cycle.
REQ-027 alu_valid with rd=0 and data=0xFFFF -> alu_ready handshake completes, w_ena stays 0, no busy bit changes.
REQ-028 Reset pulsed with the FIFO holding 2 entries and busy[7]=1 -> all outputs 0 and busy[7]=0 immediately; after release, no w_ena without new input.
REQ-029 Issue rd=9 in the same cycle as writeback of rd=9 -> busy[9]=1 afterwards.
